// File: rtl/if_stage_pkg.sv
// Shared definitions for the RV32I instruction-fetch stage.
package if_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        PC_4     = 2'b00,
        PC_IMM   = 2'b01,
        PC_IMMRS = 2'b10
    } branch_ctrl_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        KILL = 2'b10
    } if_state_t;

endpackage

// File: rtl/if_fetch_buf.sv
// One-entry fetch buffer holding a response that IF/ID could not accept yet.
module if_fetch_buf
    import if_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            wr,
    input  logic [XLEN-1:0] wr_pc,
    input  logic [XLEN-1:0] wr_inst,
    input  logic            drain,
    input  logic            flush,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] inst,
    output logic            valid
);

    // A write may coincide with a drain: the old entry moves to IF/ID, the new one stays.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            pc    <= '0;
            inst  <= NOP_INST;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (wr) begin
            valid <= 1'b1;
            pc    <= wr_pc;
            inst  <= wr_inst;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: fetch PC, one-deep fetch buffer and IF/ID register.
// Optional macro IF_PERF_CNT_EN adds kept/killed response counters.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      BranchCtrl,
    input  logic [XLEN-1:0] pc_imm,
    input  logic [XLEN-1:0] pc_immrs,
    input  logic            Flush,
    input  logic            IFID_RegWrite,
    input  logic            PCWrite,
    output logic            im_req,
    output logic [XLEN-1:0] im_addr,
    input  logic            im_rvalid,
    input  logic [XLEN-1:0] im_rdata,
    output logic [XLEN-1:0] ID_pc,
    output logic [XLEN-1:0] ID_inst,
    output logic            ID_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [XLEN-1:0] perf_fetch_cnt,
    output logic [XLEN-1:0] perf_kill_cnt
`endif
);

    if_state_t       state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] buf_pc;
    logic [XLEN-1:0] buf_inst;
    logic            buf_valid;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic            kept;
    logic            discard;
    logic            bypass;
    logic            buf_wr;
    logic            drain;
    logic            slot_free;
    logic            issue;

    // Issue decision is combinational so a 1-cycle memory sustains one fetch per cycle.
    always_comb begin
        redirect  = (BranchCtrl != PC_4);
        target    = (BranchCtrl == PC_IMMRS) ? (pc_immrs & ~32'h1) : pc_imm;
        kept      = (state == WAIT) && im_rvalid && !redirect;
        discard   = im_rvalid && ((state == KILL) || ((state == WAIT) && redirect));
        drain     = IFID_RegWrite && !Flush && buf_valid;
        bypass    = kept && IFID_RegWrite && !Flush && !buf_valid;
        buf_wr    = kept && !bypass;
        slot_free = (!buf_valid || drain) && !buf_wr;
        issue     = !rst && PCWrite && !redirect && slot_free &&
                    ((state == IDLE) || ((state == WAIT) && im_rvalid));
        im_req    = issue;
        im_addr   = fetch_pc;
    end

    if_fetch_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr      (buf_wr),
        .wr_pc   (req_pc),
        .wr_inst (im_rdata),
        .drain   (drain),
        .flush   (redirect),
        .pc      (buf_pc),
        .inst    (buf_inst),
        .valid   (buf_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            ID_pc    <= '0;
            ID_inst  <= NOP_INST;
            ID_valid <= 1'b0;
        end else begin
            assert (!(buf_wr && buf_valid && !drain));

            case (state)
                IDLE:    state <= issue ? WAIT : IDLE;
                WAIT: begin
                    if (im_rvalid)     state <= issue ? WAIT : IDLE;
                    else if (redirect) state <= KILL;
                    else               state <= WAIT;
                end
                KILL:    state <= im_rvalid ? IDLE : KILL;
                default: state <= IDLE;
            endcase

            if (redirect)   fetch_pc <= target;
            else if (issue) fetch_pc <= fetch_pc + 32'd4;

            if (issue) req_pc <= fetch_pc;

            // Buffered entry is older than any bypassed response.
            if (IFID_RegWrite) begin
                if (Flush) begin
                    ID_inst  <= NOP_INST;
                    ID_valid <= 1'b0;
                end else if (buf_valid) begin
                    ID_pc    <= buf_pc;
                    ID_inst  <= buf_inst;
                    ID_valid <= 1'b1;
                end else if (bypass) begin
                    ID_pc    <= req_pc;
                    ID_inst  <= im_rdata;
                    ID_valid <= 1'b1;
                end else begin
                    ID_inst  <= NOP_INST;
                    ID_valid <= 1'b0;
                end
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_kill_cnt  <= '0;
        end else begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'(kept);
            perf_kill_cnt  <= perf_kill_cnt + 32'(discard) +
                              32'(redirect && buf_valid && !drain);
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a variable-latency addr-as-data memory model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  BranchCtrl;
    logic [31:0] pc_imm;
    logic [31:0] pc_immrs;
    logic        Flush;
    logic        IFID_RegWrite;
    logic        PCWrite;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_rvalid;
    logic [31:0] im_rdata;
    logic [31:0] ID_pc;
    logic [31:0] ID_inst;
    logic        ID_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_kill_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 1;

    logic        pend;
    int          cnt;
    logic [31:0] mem_addr;

    always #5 clk = ~clk;

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .BranchCtrl    (BranchCtrl),
        .pc_imm        (pc_imm),
        .pc_immrs      (pc_immrs),
        .Flush         (Flush),
        .IFID_RegWrite (IFID_RegWrite),
        .PCWrite       (PCWrite),
        .im_req        (im_req),
        .im_addr       (im_addr),
        .im_rvalid     (im_rvalid),
        .im_rdata      (im_rdata),
        .ID_pc         (ID_pc),
        .ID_inst       (ID_inst),
        .ID_valid      (ID_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_kill_cnt (perf_kill_cnt)
`endif
    );

    // Response arrives exactly lat cycles after the request cycle; data = address.
    always @(posedge clk) begin
        if (rst) begin
            im_rvalid <= 1'b0;
            im_rdata  <= 32'h0;
            pend      <= 1'b0;
            cnt       <= 0;
            mem_addr  <= 32'h0;
        end else begin
            im_rvalid <= 1'b0;
            if (im_req) begin
                if (lat == 1) begin
                    im_rvalid <= 1'b1;
                    im_rdata  <= im_addr;
                end else begin
                    pend     <= 1'b1;
                    cnt      <= lat - 2;
                    mem_addr <= im_addr;
                end
            end else if (pend) begin
                if (cnt == 0) begin
                    im_rvalid <= 1'b1;
                    im_rdata  <= mem_addr;
                    pend      <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; BranchCtrl = 2'b00; pc_imm = 32'h0; pc_immrs = 32'h0;
        Flush = 1'b0; IFID_RegWrite = 1'b1; PCWrite = 1'b1;

        // Reset state, 1-cycle memory
        step(); step();
        check("rst_id_valid", 32'(ID_valid), 32'h0);
        check("rst_id_inst",  ID_inst,       32'h13);
        check("rst_id_pc",    ID_pc,         32'h0);
        check("rst_im_req",   32'(im_req),   32'h0);
        rst = 1'b0; #1;
        check("c0_req",  32'(im_req), 32'h1);
        check("c0_addr", im_addr,     32'h0);
        step();
        check("c1_addr",  im_addr,       32'h4);
        check("c1_valid", 32'(ID_valid), 32'h0);
        step();
        check("c2_addr",  im_addr,       32'h8);
        check("c2_idpc",  ID_pc,         32'h0);
        check("c2_valid", 32'(ID_valid), 32'h1);
        step();
        check("c3_addr", im_addr, 32'hC);
        check("c3_idpc", ID_pc,   32'h4);
        check("c3_inst", ID_inst, 32'h4);

        // Stall both IF/ID and PC for two cycles
        step();
        IFID_RegWrite = 1'b0; PCWrite = 1'b0; #1;
        check("st0_idpc", ID_pc,       32'h8);
        check("st0_req",  32'(im_req), 32'h0);
        step();
        check("st1_idpc", ID_pc,       32'h8);
        check("st1_req",  32'(im_req), 32'h0);
        step();
        IFID_RegWrite = 1'b1; PCWrite = 1'b1; #1;
        check("st2_idpc", ID_pc,       32'h8);
        check("st2_req",  32'(im_req), 32'h1);
        check("st2_addr", im_addr,     32'h10);
        step();
        check("rs_idpc",  ID_pc,   32'hC);
        check("rs_inst",  ID_inst, 32'hC);
        check("rs_addr",  im_addr, 32'h14);
        step();
        check("rs2_idpc", ID_pc, 32'h10);

        // Taken branch with flush
        BranchCtrl = 2'b01; pc_imm = 32'h100; Flush = 1'b1; #1;
        check("br_req", 32'(im_req), 32'h0);
        step();
        BranchCtrl = 2'b00; Flush = 1'b0; #1;
        check("br_b1_valid", 32'(ID_valid), 32'h0);
        check("br_b1_inst",  ID_inst,       32'h13);
        check("br_addr",     im_addr,       32'h100);
        check("br_req1",     32'(im_req),   32'h1);
        step();
        check("br_b2_valid", 32'(ID_valid), 32'h0);
        check("br_addr2",    im_addr,       32'h104);
        step();
        check("br_idpc",  ID_pc,         32'h100);
        check("br_inst",  ID_inst,       32'h100);
        check("br_valid", 32'(ID_valid), 32'h1);

        // Reserved BranchCtrl=11 behaves as PC_IMM; PC wraps at 2^32
        BranchCtrl = 2'b11; pc_imm = 32'hFFFF_FFFC; pc_immrs = 32'h555; Flush = 1'b1;
        step();
        BranchCtrl = 2'b00; Flush = 1'b0; #1;
        check("wr_addr0", im_addr, 32'hFFFF_FFFC);
        step();
        check("wr_addr1", im_addr, 32'h0);
        step();
        check("wr_idpc0", ID_pc, 32'hFFFF_FFFC);
        step();
        check("wr_idpc1", ID_pc,   32'h0);
        check("wr_inst1", ID_inst, 32'h0);

        // 3-cycle memory, jalr redirect while a request is outstanding
        rst = 1'b1; lat = 3;
        step();
        rst = 1'b0; #1;
        check("k0_addr", im_addr, 32'h0);
        step();
        BranchCtrl = 2'b10; pc_immrs = 32'h201; Flush = 1'b1; #1;
        check("k1_req", 32'(im_req), 32'h0);
        step();
        BranchCtrl = 2'b00; Flush = 1'b0; #1;
        check("k2_req",   32'(im_req),   32'h0);
        check("k2_valid", 32'(ID_valid), 32'h0);
        step();
        check("k3_req",   32'(im_req),   32'h0);
        check("k3_valid", 32'(ID_valid), 32'h0);
        step();
        check("k4_req",   32'(im_req),   32'h1);
        check("k4_addr",  im_addr,       32'h200);
        check("k4_valid", 32'(ID_valid), 32'h0);
`ifdef IF_PERF_CNT_EN
        check("k4_perf_kill", perf_kill_cnt, 32'h1);
`endif
        step();
        check("k5_req", 32'(im_req), 32'h0);
        step();
        check("k6_valid", 32'(ID_valid), 32'h0);
        step();
        check("k7_addr",  im_addr,       32'h204);
        check("k7_valid", 32'(ID_valid), 32'h0);
        step();
        check("k8_idpc",  ID_pc,         32'h200);
        check("k8_inst",  ID_inst,       32'h200);
        check("k8_valid", 32'(ID_valid), 32'h1);
`ifdef IF_PERF_CNT_EN
        check("k8_perf_fetch", perf_fetch_cnt, 32'h1);
        check("k8_perf_kill",  perf_kill_cnt,  32'h1);
`endif

        // Reset while a request is outstanding
        rst = 1'b1;
        step();
        check("wr_rst_inst",  ID_inst,       32'h13);
        check("wr_rst_valid", 32'(ID_valid), 32'h0);
        check("wr_rst_req",   32'(im_req),   32'h0);
        rst = 1'b0; #1;
        check("wr_rst_addr", im_addr,     32'h0);
        check("wr_rst_req1", 32'(im_req), 32'h1);
        step(); step(); step();
        check("wr_rst_v3", 32'(ID_valid), 32'h0);
        step();
        check("wr_rst_idpc",  ID_pc,         32'h0);
        check("wr_rst_valid4", 32'(ID_valid), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
